host_port_arbiter: RTL and testbench

Round-robin arbiter that shares one host memory channel between two accelerator wrappers, such as two `encrypt1` wrapper instances. The host channel has an independent read path and write path. Each path is granted separately, for a whole burst at a time. The block sits between the wrappers' read/write handshake ports and the host-side shell. Per-path grant is registered; data and handshake signals are muxed combinationally from that grant.

---
 rtl/host_if_pkg.sv | 23 ++
 rtl/path_rr_fsm.sv | 71 +++++++
 rtl/host_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_host_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/host_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : host_if_pkg
//  Purpose  : Shared definitions for the host memory channel arbiter:
//             path FSM state encoding and default bus widths.
//  Revision : 1.0 - initial release
// ============================================================================
package host_if_pkg;

    // Default address/size width and data width of the host channel
    localparam int ADDR_WID_DEF = 64;
    localparam int DATA_WID_DEF = 32;

    // Per-path arbitration state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } path_state_t;

endpackage : host_if_pkg
`default_nettype wire

// File: rtl/path_rr_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : path_rr_fsm
//  Purpose  : Two-client round-robin burst arbiter for one channel path.
//             A grant is held for as long as the owner keeps its request
//             high. It is followed by one mandatory idle (GAP) cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module path_rr_fsm
    import host_if_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       gap
);

    path_state_t state;
    // last = client that most recently finished a burst; a tie goes to the other
    logic        last;

    // Arbitration FSM with registered one-hot grant and gap flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            grant <= 2'b00;
            gap   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req[0] && (!req[1] || last)) begin
                        state <= ST_OWN0;
                        grant <= 2'b01;
                    end else if (req[1]) begin
                        state <= ST_OWN1;
                        grant <= 2'b10;
                    end
                end
                ST_OWN0: begin
                    if (!req[0]) begin
                        state <= ST_GAP;
                        last  <= 1'b0;
                        grant <= 2'b00;
                        gap   <= 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (!req[1]) begin
                        state <= ST_GAP;
                        last  <= 1'b1;
                        grant <= 2'b00;
                        gap   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                    gap   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                    gap   <= 1'b0;
                end
            endcase
        end
    end

endmodule : path_rr_fsm
`default_nettype wire

// File: rtl/host_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : host_port_arbiter
//  Purpose  : Shares one host memory channel between two accelerator
//             wrappers. The read and write paths are arbitrated
//             independently, one burst at a time. Grants are registered, and
//             the request, data and ready signals are muxed combinationally
//             from the grant.
//  Revision : 1.0 - initial release
// ============================================================================
module host_port_arbiter
    import host_if_pkg::*;
#(
    parameter int ADDR_WID = ADDR_WID_DEF,
    parameter int DATA_WID = DATA_WID_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    // client 0
    input  logic                c0_read_enable,
    input  logic [ADDR_WID-1:0] c0_read_addr,
    input  logic [ADDR_WID-1:0] c0_read_size,
    input  logic                c0_finish_read,
    output logic                c0_read_ready,
    output logic [DATA_WID-1:0] c0_read_data,
    input  logic                c0_write_enable,
    input  logic [ADDR_WID-1:0] c0_write_addr,
    input  logic [ADDR_WID-1:0] c0_write_size,
    input  logic [DATA_WID-1:0] c0_write_data,
    input  logic                c0_finish_write,
    output logic                c0_write_ready,
    input  logic                c0_done,
    // client 1
    input  logic                c1_read_enable,
    input  logic [ADDR_WID-1:0] c1_read_addr,
    input  logic [ADDR_WID-1:0] c1_read_size,
    input  logic                c1_finish_read,
    output logic                c1_read_ready,
    output logic [DATA_WID-1:0] c1_read_data,
    input  logic                c1_write_enable,
    input  logic [ADDR_WID-1:0] c1_write_addr,
    input  logic [ADDR_WID-1:0] c1_write_size,
    input  logic [DATA_WID-1:0] c1_write_data,
    input  logic                c1_finish_write,
    output logic                c1_write_ready,
    input  logic                c1_done,
    // host side
    output logic                read_enable,
    output logic [ADDR_WID-1:0] read_addr,
    output logic [ADDR_WID-1:0] read_size_output,
    output logic                finish_read,
    input  logic                read_ready,
    input  logic [DATA_WID-1:0] read_data,
    output logic                write_enable,
    output logic [ADDR_WID-1:0] write_addr,
    output logic [ADDR_WID-1:0] write_size,
    output logic [DATA_WID-1:0] write_data,
    output logic                finish_write,
    input  logic                write_ready,
    // status
    output logic                done,
    output logic [1:0]          rd_grant,
    output logic [1:0]          wr_grant
);

    logic       rd_gap;
    logic       wr_gap;
    logic [1:0] rd_own;
    logic [1:0] wr_own;
    logic       seen0;
    logic       seen1;

    path_rr_fsm u_rd_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({c1_read_enable, c0_read_enable}),
        .grant   (rd_grant),
        .gap     (rd_gap)
    );

    path_rr_fsm u_wr_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({c1_write_enable, c0_write_enable}),
        .grant   (wr_grant),
        .gap     (wr_gap)
    );

    // The grant is already zero in GAP; masking with gap keeps the host
    // side quiet even if a grant bit were ever to linger.
    assign rd_own = rd_grant & {2{~rd_gap}};
    assign wr_own = wr_grant & {2{~wr_gap}};

    // Read path: host request from the owner, ready gated back to the owner only
    always_comb begin
        read_enable      = 1'b0;
        read_addr        = '0;
        read_size_output = '0;
        finish_read      = 1'b0;
        if (rd_own[0]) begin
            read_enable      = c0_read_enable;
            read_addr        = c0_read_addr;
            read_size_output = c0_read_size;
            finish_read      = c0_finish_read;
        end else if (rd_own[1]) begin
            read_enable      = c1_read_enable;
            read_addr        = c1_read_addr;
            read_size_output = c1_read_size;
            finish_read      = c1_finish_read;
        end
    end

    assign c0_read_ready = read_ready & rd_own[0];
    assign c1_read_ready = read_ready & rd_own[1];
    // Read data is broadcast; only the owner sees ready, so only it consumes.
    assign c0_read_data  = read_data;
    assign c1_read_data  = read_data;

    // Write path: host request and data from the owner
    always_comb begin
        write_enable = 1'b0;
        write_addr   = '0;
        write_size   = '0;
        write_data   = '0;
        finish_write = 1'b0;
        if (wr_own[0]) begin
            write_enable = c0_write_enable;
            write_addr   = c0_write_addr;
            write_size   = c0_write_size;
            write_data   = c0_write_data;
            finish_write = c0_finish_write;
        end else if (wr_own[1]) begin
            write_enable = c1_write_enable;
            write_addr   = c1_write_addr;
            write_size   = c1_write_size;
            write_data   = c1_write_data;
            finish_write = c1_finish_write;
        end
    end

    assign c0_write_ready = write_ready & wr_own[0];
    assign c1_write_ready = write_ready & wr_own[1];

    // Sticky per-client completion flags, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen0 <= 1'b0;
            seen1 <= 1'b0;
        end else begin
            seen0 <= seen0 | c0_done;
            seen1 <= seen1 | c1_done;
        end
    end

    assign done = seen0 & seen1;

endmodule : host_port_arbiter
`default_nettype wire

// File: tb/tb_host_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_host_port_arbiter
//  Purpose  : Directed self-checking bench for host_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_host_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          c0_read_enable, c0_finish_read, c0_read_ready;
    logic [AW-1:0] c0_read_addr, c0_read_size;
    logic [DW-1:0] c0_read_data;
    logic          c0_write_enable, c0_finish_write, c0_write_ready, c0_done;
    logic [AW-1:0] c0_write_addr, c0_write_size;
    logic [DW-1:0] c0_write_data;
    logic          c1_read_enable, c1_finish_read, c1_read_ready;
    logic [AW-1:0] c1_read_addr, c1_read_size;
    logic [DW-1:0] c1_read_data;
    logic          c1_write_enable, c1_finish_write, c1_write_ready, c1_done;
    logic [AW-1:0] c1_write_addr, c1_write_size;
    logic [DW-1:0] c1_write_data;
    logic          read_enable, finish_read, read_ready;
    logic [AW-1:0] read_addr, read_size_output;
    logic [DW-1:0] read_data;
    logic          write_enable, finish_write, write_ready;
    logic [AW-1:0] write_addr, write_size;
    logic [DW-1:0] write_data;
    logic          done;
    logic [1:0]    rd_grant, wr_grant;

    int n_checks = 0;
    int n_fail   = 0;

    host_port_arbiter #(.ADDR_WID(AW), .DATA_WID(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_read_enable(c0_read_enable), .c0_read_addr(c0_read_addr),
        .c0_read_size(c0_read_size), .c0_finish_read(c0_finish_read),
        .c0_read_ready(c0_read_ready), .c0_read_data(c0_read_data),
        .c0_write_enable(c0_write_enable), .c0_write_addr(c0_write_addr),
        .c0_write_size(c0_write_size), .c0_write_data(c0_write_data),
        .c0_finish_write(c0_finish_write), .c0_write_ready(c0_write_ready),
        .c0_done(c0_done),
        .c1_read_enable(c1_read_enable), .c1_read_addr(c1_read_addr),
        .c1_read_size(c1_read_size), .c1_finish_read(c1_finish_read),
        .c1_read_ready(c1_read_ready), .c1_read_data(c1_read_data),
        .c1_write_enable(c1_write_enable), .c1_write_addr(c1_write_addr),
        .c1_write_size(c1_write_size), .c1_write_data(c1_write_data),
        .c1_finish_write(c1_finish_write), .c1_write_ready(c1_write_ready),
        .c1_done(c1_done),
        .read_enable(read_enable), .read_addr(read_addr),
        .read_size_output(read_size_output), .finish_read(finish_read),
        .read_ready(read_ready), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_size(write_size), .write_data(write_data),
        .finish_write(finish_write), .write_ready(write_ready),
        .done(done), .rd_grant(rd_grant), .wr_grant(wr_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point of the current cycle
    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        c0_read_enable = 0; c0_read_addr = '0; c0_read_size = '0; c0_finish_read = 0;
        c0_write_enable = 0; c0_write_addr = '0; c0_write_size = '0; c0_write_data = '0;
        c0_finish_write = 0; c0_done = 0;
        c1_read_enable = 0; c1_read_addr = '0; c1_read_size = '0; c1_finish_read = 0;
        c1_write_enable = 0; c1_write_addr = '0; c1_write_size = '0; c1_write_data = '0;
        c1_finish_write = 0; c1_done = 0;
        read_ready = 0; read_data = '0; write_ready = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    logic [1:0] alt_exp [3];

    initial begin
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01;
        reset_n = 1'b0;
        clear_inputs();
        do_reset();

        // ---------------- reset state ----------------
        samp();
        check("rst_rd_grant", 64'(rd_grant), 64'd0);
        check("rst_wr_grant", 64'(wr_grant), 64'd0);
        check("rst_read_en", 64'(read_enable), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // ---------------- solo read by c0 ----------------
        tick();
        c0_read_enable = 1; c0_read_addr = 64'h1000; c0_read_size = 64'd4; read_ready = 1;
        samp();
        check("solo_req_cycle_grant", 64'(rd_grant), 64'd0);
        check("solo_req_cycle_ready", 64'(c0_read_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            c0_read_addr = 64'h1000 + 64'(4 * i);
            c0_finish_read = 1;
            read_data = 32'hA000_0000 + 32'(i);
            samp();
            check("solo_grant", 64'(rd_grant), 64'h1);
            check("solo_addr", read_addr, 64'h1000 + 64'(4 * i));
            check("solo_size", read_size_output, 64'd4);
            check("solo_c0_ready", 64'(c0_read_ready), 64'd1);
            check("solo_c1_ready", 64'(c1_read_ready), 64'd0);
            check("solo_finish", 64'(finish_read), 64'd1);
            check("solo_data", 64'(c0_read_data), 64'(32'hA000_0000 + 32'(i)));
        end
        tick();
        c0_read_enable = 0; c0_finish_read = 0;
        samp();
        check("solo_release_en_same_cycle", 64'(read_enable), 64'd0);
        check("solo_release_grant_held", 64'(rd_grant), 64'h1);
        tick();
        samp();
        check("solo_gap_grant", 64'(rd_grant), 64'd0);
        check("solo_gap_ready", 64'(c0_read_ready), 64'd0);

        // sticky done: needs both flags, in any order
        tick(); c0_done = 1;
        tick(); c0_done = 0;
        samp();
        check("done_one_flag", 64'(done), 64'd0);
        tick(); c1_done = 1;
        tick(); c1_done = 0;
        samp();
        check("done_both_flags", 64'(done), 64'd1);

        // ---------------- tie after reset ----------------
        do_reset();
        c0_read_enable = 1; c1_read_enable = 1; read_ready = 1;
        c0_read_addr = 64'h2000; c1_read_addr = 64'h3000;
        tick();
        samp();
        check("tie_first_c0", 64'(rd_grant), 64'h1);
        check("tie_c1_ready_blocked", 64'(c1_read_ready), 64'd0);
        tick();
        c0_read_enable = 0;
        samp();
        check("tie_release_en", 64'(read_enable), 64'd0);
        tick();
        samp();
        check("tie_gap_grant", 64'(rd_grant), 64'd0);
        check("tie_gap_en", 64'(read_enable), 64'd0);
        check("tie_gap_c1_ready", 64'(c1_read_ready), 64'd0);
        tick();
        samp();
        check("tie_idle_grant", 64'(rd_grant), 64'd0);
        tick();
        samp();
        check("tie_second_c1", 64'(rd_grant), 64'h2);
        check("tie_c1_addr", read_addr, 64'h3000);
        check("tie_c1_en", 64'(read_enable), 64'd1);

        // ---------------- alternation 0,1,0 ----------------
        do_reset();
        c0_read_enable = 1; c1_read_enable = 1;
        tick();
        for (int b = 0; b < 3; b++) begin
            samp();
            check("alt_grant", 64'(rd_grant), 64'(alt_exp[b]));
            tick();
            samp();
            check("alt_grant_hold", 64'(rd_grant), 64'(alt_exp[b]));
            tick();
            if (alt_exp[b][0]) c0_read_enable = 0; else c1_read_enable = 0;
            samp();
            check("alt_release_en", 64'(read_enable), 64'd0);
            tick();
            if (alt_exp[b][0]) c0_read_enable = 1; else c1_read_enable = 1;
            samp();
            check("alt_gap_grant", 64'(rd_grant), 64'd0);
            tick();
            samp();
            check("alt_idle_grant", 64'(rd_grant), 64'd0);
            tick();
        end

        // ---------------- independent paths + stray finish + reset mid-burst ----------------
        do_reset();
        c0_read_enable = 1; c0_read_addr = 64'h4000; c0_read_size = 64'd2;
        c1_write_enable = 1; c1_write_addr = 64'h8000; c1_write_size = 64'd2;
        read_ready = 1; write_ready = 1;
        tick();
        c1_write_data = 32'hDEADBEEF; c1_finish_write = 1;
        c1_finish_read = 1; c0_done = 1; c1_done = 1;
        samp();
        check("ind_rd_grant", 64'(rd_grant), 64'h1);
        check("ind_wr_grant", 64'(wr_grant), 64'h2);
        check("ind_wdata0", 64'(write_data), 64'hDEADBEEF);
        check("ind_waddr", write_addr, 64'h8000);
        check("ind_wfinish", 64'(finish_write), 64'd1);
        check("ind_c1_wready", 64'(c1_write_ready), 64'd1);
        check("ind_c0_wready", 64'(c0_write_ready), 64'd0);
        check("ind_read_en", 64'(read_enable), 64'd1);
        check("stray_finish_read", 64'(finish_read), 64'd0);
        check("stray_c1_rready", 64'(c1_read_ready), 64'd0);
        tick();
        c1_write_data = 32'hCAFEF00D; c1_finish_read = 0; c0_done = 0; c1_done = 0;
        c0_finish_read = 1;
        samp();
        check("ind_wdata1", 64'(write_data), 64'hCAFEF00D);
        check("stray_c0_unaffected", 64'(finish_read), 64'd1);
        check("stray_c0_grant", 64'(rd_grant), 64'h1);
        check("ind_done_set", 64'(done), 64'd1);
        // async reset in the middle of the cycle, write_enable still high
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_write_en", 64'(write_enable), 64'd0);
        check("rst_mid_read_en", 64'(read_enable), 64'd0);
        check("rst_mid_wr_grant", 64'(wr_grant), 64'd0);
        check("rst_mid_rd_grant", 64'(rd_grant), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_c1_wready", 64'(c1_write_ready), 64'd0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_host_port_arbiter
`default_nettype wire
